// File: rtl/decode_req_encoder.sv
// Active-low request capture and binary encoder with a valid/ready output.
// Requests are captured as levels into a pending vector. One request at a time
// is presented as a binary code, picked either by fixed priority (index 7
// highest) or round-robin after the last served index.
//
// Handshake: code is presented while valid is high. It is consumed on a rising
// edge where valid and ready are both high. code and valid stay stable while
// ready is low. code keeps its last value while valid is low.
module decode_req_encoder #(
    parameter int RR_MODE = 0
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       enable_n,
    input  logic [7:0] D_n,
    input  logic       ready,
    output logic [2:0] code,
    output logic       valid,
    output logic [7:0] pending,
    output logic       any_n
);

    typedef enum logic {
        IDLE    = 1'b0,
        PRESENT = 1'b1
    } state_t;

    state_t     state_q, state_d;
    logic [7:0] pending_q, pending_d;
    logic [2:0] code_q, code_d;
    logic [2:0] ptr_q, ptr_d;
    logic       any_n_q, any_n_d;

    logic [7:0] capture;
    logic [7:0] clear_mask;
    logic       handshake;
    logic [3:0] sel_idle;
    logic [3:0] sel_next;

    // Returns {found, index}. In fixed mode the highest set bit wins.
    // In round-robin mode the search starts at base-1, moves downward and
    // wraps from 0 to 7. Base itself is tried last.
    function automatic logic [3:0] select_idx(input logic [7:0] vec, input logic [2:0] base);
        logic       found;
        logic [2:0] idx;
        logic [2:0] j;
        found = 1'b0;
        idx   = 3'd0;
        j     = 3'd0;
        if (RR_MODE == 0) begin
            for (int i = 0; i < 8; i++) begin
                if (vec[i]) begin
                    found = 1'b1;
                    idx   = 3'(i);
                end
            end
        end else begin
            for (int k = 1; k <= 8; k++) begin
                j = base - 3'(k);
                if (!found && vec[j]) begin
                    found = 1'b1;
                    idx   = j;
                end
            end
        end
        return {found, idx};
    endfunction

    // Next-state logic: capture, handshake clear, selection and state transition.
    always_comb begin
        capture    = enable_n ? 8'h00 : ~D_n;
        handshake  = (state_q == PRESENT) && ready;
        clear_mask = handshake ? (8'b1 << code_q) : 8'h00;
        // The capture is OR-ed in after the clear. A line that is still held
        // low on the handshake edge therefore stays pending.
        pending_d  = (pending_q & ~clear_mask) | capture;
        sel_idle   = select_idx(pending_q, ptr_q);
        sel_next   = select_idx(pending_d, code_q);
        state_d    = state_q;
        code_d     = code_q;
        ptr_d      = ptr_q;
        case (state_q)
            IDLE: begin
                if (sel_idle[3]) begin
                    state_d = PRESENT;
                    code_d  = sel_idle[2:0];
                end
            end
            PRESENT: begin
                if (handshake) begin
                    ptr_d = code_q;
                    if (sel_next[3]) begin
                        code_d = sel_next[2:0];
                    end else begin
                        state_d = IDLE;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
        any_n_d = ~((|pending_d) | (state_d == PRESENT));
    end

    // State register. Reset takes priority over capture and handshake.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= IDLE;
            pending_q <= 8'h00;
            code_q    <= 3'd0;
            ptr_q     <= 3'd0;
            any_n_q   <= 1'b1;
        end else begin
            state_q   <= state_d;
            pending_q <= pending_d;
            code_q    <= code_d;
            ptr_q     <= ptr_d;
            any_n_q   <= any_n_d;
        end
    end

    assign code    = code_q;
    assign valid   = (state_q == PRESENT);
    assign pending = pending_q;
    assign any_n   = any_n_q;

endmodule

// File: doc/decode_req_encoder.md
DECODE_REQ_ENCODER -- requirements
Module: decode_req_encoder

Interface
REQ-001 The module SHALL have parameter RR_MODE, default 0, meaning arbitration policy: 0 = fixed priority (index 7 highest), 1 = round-robin.
REQ-002 Port clk, input, 1, sole clock; all state updates on rising edge.
REQ-003 Port rst, input, 1, reset; synchronous, active-high.
REQ-004 Port enable_n, input, 1, active-low capture enable.
REQ-005 Port D_n, input, 8, active-low request lines; bit i low = request i.
REQ-006 Port ready, input, 1, consumer accepts code when high together with valid.
REQ-007 Port code, output, 3, registered binary index of presented request.
REQ-008 Port valid, output, 1, registered; code is meaningful while high.
REQ-009 Port pending, output, 8, registered pending-request vector (active-high).
REQ-010 Port any_n, output, 1, registered; low when pending != 0 or valid = 1.

Function
REQ-011 Capture: each edge with enable_n = 0, pending |= ~D_n; enable_n = 1 blocks capture only; draining continues.
REQ-012 Levels are captured, not edges: a line held low keeps its pending bit set after every service.
REQ-013 States SHALL be IDLE (valid = 0) and PRESENT (valid = 1).
REQ-014 IDLE -> PRESENT when pending != 0; code loaded with selected index on the same edge.
REQ-015 PRESENT with valid & ready: pending[code] cleared; if remaining pending (after clear, plus new captures) != 0, next index loaded, stay PRESENT; else -> IDLE.
REQ-016 PRESENT with ready = 0: code, valid held stable; higher-priority arrivals only set pending bits.
REQ-017 Clear and capture of the same bit on the same edge: set wins; bit stays pending and is served again.
REQ-018 RR_MODE = 0: selection = highest set index.
REQ-019 RR_MODE = 1: pointer p (3 bits) = last served index; search p-1, p-2, ... wrapping 0 -> 7, first set bit wins; p updated on each handshake.
REQ-020 Latency: D_n bit low sampled at edge N (IDLE, empty) -> valid = 1 with code after edge N+1.
REQ-021 Throughput: one code per cycle when ready held high and requests remain; no bubble cycles.
REQ-022 Selection for the next presentation SHALL consider requests captured on the handshake edge.
REQ-023 code SHALL retain its last value while valid = 0.
REQ-024 any_n SHALL be computed from next-state pending/valid so it changes on the same edge as valid.

Reset
REQ-025 rst = 1 at an edge: pending = 8'h00, valid = 0, code = 3'd0, any_n = 1, state IDLE, p = 3'd0; overrides capture and handshake that edge.
REQ-026 Reset mid-presentation SHALL discard the presented code and all pending requests; no handshake is credited.
REQ-027 After rst deasserts, capture resumes on the first edge with enable_n = 0.

Verification
REQ-028 Single: rst, then D_n = 8'hF7 (bit 3) one cycle, ready = 1 -> valid one cycle later with code = 3, then valid = 0, pending = 0, any_n = 1.
REQ-029 Priority: D_n = 8'h5A one cycle (bits 0,2,5,7), ready = 1, RR_MODE = 0 -> codes 7,5,2,0 on consecutive cycles, then IDLE.
REQ-030 Stall: code = 2 presented, ready = 0, D_n bit 6 pulsed low -> code stays 2, pending[6] = 1; ready = 1 -> next code = 6.
REQ-031 Round-robin: RR_MODE = 1, D_n = 8'h00 held, ready = 1 -> codes cycle 7,6,5,...,0,7 with valid continuously high.
REQ-032 Enable/reset: enable_n = 1 with D_n = 8'h00 -> pending stays 0, any_n = 1; then load pending, assert rst during PRESENT -> next edge valid = 0, pending = 0, code = 0.
